// File: rtl/oven_pkg.sv
// oven_pkg: shared keypad types, widths and key-decoding helpers
package oven_pkg;
  localparam int KEY_COUNT = 10;
  localparam int KEY_CODE_W = 4;
  typedef enum logic [2:0] {IDLE, SETTLE, EMIT, HOLD, RELEASE} key_state_t;
  function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KEY_COUNT-1:0] k);
    key_index = '0;
    for (int i = 0; i < KEY_COUNT; i++)
      if (k[i]) key_index = KEY_CODE_W'(i);
  endfunction
  function automatic logic [KEY_CODE_W-1:0] key_count(input logic [KEY_COUNT-1:0] k);
    key_count = '0;
    for (int i = 0; i < KEY_COUNT; i++)
      key_count = key_count + KEY_CODE_W'(k[i]);
  endfunction
endpackage

// File: rtl/key_encoder_settle_counter.sv
// settle_counter: counts consecutive stable samples for press and release qualification
module settle_counter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear_n,
  input  logic load,
  input  logic inc,
  output logic done
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? 4'd1 : inc ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == 4'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/key_encoder.sv
// key_encoder: debounced, no-repeat one-hot keypad to digit-code encoder
module key_encoder
  import oven_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic [KEY_COUNT-1:0]  keypad,
  output logic [KEY_CODE_W-1:0] code,
  output logic                  valid,
  output logic                  busy,
  output logic                  multi
);
  key_state_t state_q, state_d;
  logic [KEY_COUNT-1:0] cand_q, cand_d;
  logic [KEY_CODE_W-1:0] code_q, keys;
  logic valid_q, multi_q, load, inc, done, quiet;
  assign keys = key_count(keypad);
  assign quiet = keypad == '0;
  settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_cnt (
    .clock(clock), .clear_n(clear_n), .load(load), .inc(inc), .done(done)
  );
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    load = 1'b0;
    inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (keys == 4'd1) begin
          cand_d = keypad;
          load = 1'b1;
          state_d = SETTLE;
        end else if (!quiet) state_d = HOLD;
      end
      SETTLE: begin
        if (keypad == cand_q) begin
          state_d = done ? EMIT : SETTLE;
          inc = !done;
        end else state_d = quiet ? IDLE : HOLD;
      end
      EMIT: state_d = HOLD;
      HOLD: begin
        load = quiet;
        state_d = quiet ? RELEASE : HOLD;
      end
      RELEASE: begin
        // any bounce while releasing re-arms the hold, never a second strobe
        inc = quiet && !done;
        state_d = !quiet ? HOLD : done ? IDLE : RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state_q <= IDLE;
      cand_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      code_q <= state_d == EMIT ? key_index(cand_q) : code_q;
      valid_q <= state_d == EMIT;
      multi_q <= keys > 4'd1;
    end
  assign code = code_q;
  assign valid = valid_q;
  assign busy = state_q != IDLE;
  assign multi = multi_q;
endmodule
